// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings, FSM state encoding and helper
//                function for the multi-cycle ALU (alu_mc).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_REMU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   // True for the opcodes served by the iterative multiply/divide engine.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Iterative unsigned multiply (shift-add, low WIDTH bits) and
//                restoring divide, one bit per cycle. The first step is taken
//                in the start cycle, so WIDTH steps finish WIDTH-1 cycles
//                after start; done pulses for one cycle afterwards.
//                acc_out holds product (MUL) or remainder (DIV),
//                quo_out holds the quotient (DIV).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] quo_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_one      = CW'(1);

   // r_acc: product / partial remainder; r_x: multiplicand / divisor;
   // r_y: multiplier / dividend-then-quotient.
   logic [WIDTH-1:0] r_acc, r_x, r_y;
   logic             r_div, r_run, r_done;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] w_acc_s, w_x_s, w_y_s;
   logic             w_div_s;
   logic [WIDTH-1:0] w_acc_n, w_x_n, w_y_n;
   logic [WIDTH:0]   w_tmp;
   logic             w_ge;

   // Select step source (fresh operands on start) and compute one step.
   always_comb begin
      w_acc_s = start ? '0 : r_acc;
      w_x_s   = start ? (div ? b : a) : r_x;
      w_y_s   = start ? (div ? a : b) : r_y;
      w_div_s = start ? div : r_div;
      w_tmp   = {w_acc_s, w_y_s[WIDTH-1]};
      w_ge    = (w_tmp >= {1'b0, w_x_s});
      if (w_div_s) begin
         // Trial subtract; the true difference always fits in WIDTH bits.
         w_acc_n = w_ge ? (w_tmp[WIDTH-1:0] - w_x_s) : w_tmp[WIDTH-1:0];
         w_x_n   = w_x_s;
         w_y_n   = {w_y_s[WIDTH-2:0], w_ge};
      end else begin
         w_acc_n = w_acc_s + (w_y_s[0] ? w_x_s : '0);
         w_x_n   = w_x_s << 1;
         w_y_n   = w_y_s >> 1;
      end
   end

   // Datapath registers and step counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_div  <= 1'b0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         if (start || r_run) begin
            r_acc <= w_acc_n;
            r_x   <= w_x_n;
            r_y   <= w_y_n;
            r_div <= w_div_s;
         end
         if (start) begin
            r_run <= 1'b1;
            r_cnt <= c_last_cnt;
         end else if (r_run) begin
            r_cnt <= r_cnt - c_one;
            if (r_cnt == c_one) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign done    = r_done;
   assign acc_out = r_acc;
   assign quo_out = r_y;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle ALU with valid/ready handshakes. Logic, add/sub,
//                signed compare and shifts complete in one cycle; MUL/DIVU/
//                REMU use the iterative engine (WIDTH+1 cycle latency).
//                Build macro ALU_MULDIV_EN enables MUL/DIVU/REMU; without it
//                those opcodes are reported as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   state_t           r_state, w_state_nxt;
   logic             w_accept, w_is_md, w_md_done;
   logic [WIDTH-1:0] w_alu_res, w_md_res, w_sum, w_diff;
   logic             w_alu_ovf, w_alu_ill;
   logic [SHW-1:0]   w_sh;

   assign w_accept = in_valid && (r_state == IDLE);
   assign w_sum    = a + b;
   assign w_diff   = a - b;
   assign w_sh     = b[SHW-1:0];

   // Single-cycle result, overflow and illegal-opcode decode.
   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      w_alu_ill = 1'b0;
      case (op)
         OP_AND: w_alu_res = a & b;
         OP_OR:  w_alu_res = a | b;
         OP_NOR: w_alu_res = ~(a | b);
         OP_ADD: begin
            w_alu_res = w_sum;
            w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_diff;
            w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: w_alu_res = a << w_sh;
         OP_SRL: w_alu_res = a >> w_sh;
         OP_SRA: w_alu_res = WIDTH'($signed(a) >>> w_sh);
`ifdef ALU_MULDIV_EN
         OP_MUL, OP_DIVU, OP_REMU: w_alu_ill = 1'b0;
`endif
         default: w_alu_ill = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic [3:0]       r_op;
   logic [WIDTH-1:0] w_acc, w_quo;

   assign w_is_md = is_muldiv(op);

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst     (rst),
      .start   (w_accept && w_is_md),
      .div     (op != OP_MUL),
      .a       (a),
      .b       (b),
      .done    (w_md_done),
      .acc_out (w_acc),
      .quo_out (w_quo)
   );

   assign w_md_res = (r_op == OP_DIVU) ? w_quo : w_acc;

   // Remember which iterative op is in flight to pick its result.
   always_ff @(posedge clk) begin
      if (rst)
         r_op <= OP_AND;
      else if (w_accept)
         r_op <= op;
   end
`else
   assign w_is_md   = 1'b0;
   assign w_md_done = 1'b0;
   assign w_md_res  = '0;
`endif

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               w_state_nxt = w_is_md ? BUSY : DONE;
         end
         BUSY: begin
            if (w_md_done)
               w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register and registered result/flags, held stable in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         result   <= '0;
         zero     <= 1'b1;
         overflow <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept && !w_is_md) begin
            result   <= w_alu_res;
            zero     <= (w_alu_res == '0);
            overflow <= w_alu_ovf;
            illegal  <= w_alu_ill;
         end else if ((r_state == BUSY) && w_md_done) begin
            result   <= w_md_res;
            zero     <= (w_md_res == '0);
            overflow <= 1'b0;
            illegal  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Self-checking bench for alu_mc (WIDTH=32): directed cases
//                plus randomized operations against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero, overflow, illegal;

   int total = 0;
   int bad   = 0;

`ifdef ALU_MULDIV_EN
   localparam bit MD_ON  = 1'b1;
   localparam int MD_LAT = 33;
`else
   localparam bit MD_ON  = 1'b0;
   localparam int MD_LAT = 1;
`endif

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the opcode table.
   function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic v, output logic il);
      longint sx, sy, s;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r = 32'd0; v = 1'b0; il = 1'b0;
      case (o)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b1100: r = ~(x | y);
         4'b0010: begin s = sx + sy; r = s[31:0]; v = (s != longint'($signed(r))); end
         4'b0110: begin s = sx - sy; r = s[31:0]; v = (s != longint'($signed(r))); end
         4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
         4'b1000: r = x << y[4:0];
         4'b1001: r = x >> y[4:0];
         4'b1010: begin s = sx >>> y[4:0]; r = s[31:0]; end
`ifdef ALU_MULDIV_EN
         4'b0011: begin p = 64'(x) * 64'(y); r = p[31:0]; end
         4'b0100: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         4'b0101: r = (y == 0) ? x : x % y;
`endif
         default: il = 1'b1;
      endcase
   endfunction

   // Issue one request, wait for out_valid; returns observed outputs,
   // latency in cycles from accept (-1 on timeout) and in_ready-high cycles.
   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output logic v, output logic il,
                         output int lat, output int rdy_cnt);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
      lat = 0; rdy_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (in_ready) rdy_cnt++;
      end while (!out_valid && lat < 200);
      if (!out_valid) lat = -1;
      r = result; z = zero; v = overflow; il = illegal;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      total++; if (result !== 32'd0)    begin bad++; $display("FAIL reset result: got %h want 0", result); end
      total++; if (zero !== 1'b1)       begin bad++; $display("FAIL reset zero: got %b want 1", zero); end
      total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
      total++; if (illegal !== 1'b0)    begin bad++; $display("FAIL reset illegal: got %b want 0", illegal); end
      rst = 1'b0;
   endtask

   task automatic test_single_cycle();
      logic [3:0]  t_op[4] = '{OP_ADD, OP_SUB, OP_SLT, OP_SRA};
      logic [31:0] t_a[4]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] t_b[4]  = '{32'd1, 32'd5, 32'd1, 32'h24};
      logic [31:0] t_r[4]  = '{32'h8000_0000, 32'd0, 32'd1, 32'hF800_0000};
      logic        t_z[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic        t_v[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] r;
      logic z, v, il;
      int lat, rc;
      for (int i = 0; i < 4; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], r, z, v, il, lat, rc);
         total++; if (r !== t_r[i]) begin bad++; $display("FAIL single[%0d] result: got %h want %h", i, r, t_r[i]); end
         total++; if (z !== t_z[i]) begin bad++; $display("FAIL single[%0d] zero: got %b want %b", i, z, t_z[i]); end
         total++; if (v !== t_v[i]) begin bad++; $display("FAIL single[%0d] overflow: got %b want %b", i, v, t_v[i]); end
         total++; if (il !== 1'b0)  begin bad++; $display("FAIL single[%0d] illegal: got %b want 0", i, il); end
         total++; if (lat !== 1)    begin bad++; $display("FAIL single[%0d] latency: got %0d want 1", i, lat); end
         release_out();
      end
   endtask

   task automatic test_muldiv();
      logic [3:0]  t_op[5] = '{OP_MUL, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
      logic [31:0] t_a[5]  = '{32'h0001_0001, 32'd100, 32'd100, 32'd9, 32'd9};
      logic [31:0] t_b[5]  = '{32'h0001_0001, 32'd7, 32'd7, 32'd0, 32'd0};
      logic [31:0] t_r[5]  = '{32'h0002_0001, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
      logic [31:0] r, er;
      logic z, v, il;
      int lat, rc;
      for (int i = 0; i < 5; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], r, z, v, il, lat, rc);
         er = MD_ON ? t_r[i] : 32'd0;
         total++; if (r !== er)       begin bad++; $display("FAIL muldiv[%0d] result: got %h want %h", i, r, er); end
         total++; if (il !== !MD_ON)  begin bad++; $display("FAIL muldiv[%0d] illegal: got %b want %b", i, il, !MD_ON); end
         total++; if (lat !== MD_LAT) begin bad++; $display("FAIL muldiv[%0d] latency: got %0d want %0d", i, lat, MD_LAT); end
         total++; if (rc !== 0)       begin bad++; $display("FAIL muldiv[%0d] in_ready while busy: got %0d cycles want 0", i, rc); end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r;
      logic z, v, il;
      int lat, rc;
      run_op(OP_ADD, 32'd3, 32'd4, r, z, v, il, lat, rc);
      total++; if (r !== 32'd7) begin bad++; $display("FAIL bp first result: got %h want 7", r); end
      op = OP_OR; a = 32'd1; b = 32'd2; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp hold out_valid[%0d]: got %b want 1", i, out_valid); end
         total++; if (result !== 32'd7)   begin bad++; $display("FAIL bp hold result[%0d]: got %h want 7", i, result); end
         total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp hold in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp after handshake out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp after handshake in_ready: got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp second out_valid: got %b want 1", out_valid); end
      total++; if (result !== 32'd3)   begin bad++; $display("FAIL bp second result: got %h want 3", result); end
      release_out();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic z, v, il;
      int lat, rc;
      @(negedge clk);
      op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
      total++; if (result !== 32'd0)   begin bad++; $display("FAIL rstmid result: got %h want 0", result); end
      run_op(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, r, z, v, il, lat, rc);
      total++; if (r !== 32'h0000_F000) begin bad++; $display("FAIL rstmid and result: got %h want 0000f000", r); end
      total++; if (lat !== 1)           begin bad++; $display("FAIL rstmid and latency: got %0d want 1", lat); end
      release_out();
   endtask

   task automatic test_illegal();
      logic [31:0] r;
      logic z, v, il;
      int lat, rc;
      run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, r, z, v, il, lat, rc);
      total++; if (il !== 1'b1)  begin bad++; $display("FAIL illegal flag: got %b want 1", il); end
      total++; if (r !== 32'd0)  begin bad++; $display("FAIL illegal result: got %h want 0", r); end
      total++; if (z !== 1'b1)   begin bad++; $display("FAIL illegal zero: got %b want 1", z); end
      total++; if (lat !== 1)    begin bad++; $display("FAIL illegal latency: got %0d want 1", lat); end
      release_out();
   endtask

   task automatic test_random();
      logic [3:0]  o;
      logic [31:0] x, y, r, er;
      logic z, v, il, ev, eil;
      int lat, rc, elat;
      for (int i = 0; i < 80; i++) begin
         o = 4'($urandom_range(0, 15));
         x = $urandom;
         case ($urandom_range(0, 3))
            0:       y = x;
            1:       y = 32'($urandom_range(0, 40));
            default: y = $urandom;
         endcase
         model(o, x, y, er, ev, eil);
         elat = (MD_ON && (o == OP_MUL || o == OP_DIVU || o == OP_REMU)) ? 33 : 1;
         run_op(o, x, y, r, z, v, il, lat, rc);
         total++; if (r !== er)             begin bad++; $display("FAIL rand[%0d] op=%h a=%h b=%h result: got %h want %h", i, o, x, y, r, er); end
         total++; if (z !== (er == 32'd0))  begin bad++; $display("FAIL rand[%0d] op=%h zero: got %b want %b", i, o, z, (er == 32'd0)); end
         total++; if (v !== ev)             begin bad++; $display("FAIL rand[%0d] op=%h overflow: got %b want %b", i, o, v, ev); end
         total++; if (il !== eil)           begin bad++; $display("FAIL rand[%0d] op=%h illegal: got %b want %b", i, o, il, eil); end
         total++; if (lat !== elat)         begin bad++; $display("FAIL rand[%0d] op=%h latency: got %0d want %0d", i, o, lat, elat); end
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_muldiv();
      test_backpressure();
      test_reset_mid();
      test_illegal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
